// File: rtl/pll_reset_seq_if.sv
// Handshake bundle between the PLL reset sequencer and its surroundings.
// slave is the sequencer side, master drives lock and soft-reset requests.
interface pll_reset_seq_if;
  logic       pll_lock;
  logic       soft_rst_req;
  logic       sys_rst_n;
  logic       bus_rst_n;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic       pll_reset;

  modport master (
    output pll_lock,
    output soft_rst_req,
    input  sys_rst_n,
    input  bus_rst_n,
    input  ready,
    input  lock_loss_cnt,
    input  pll_reset
  );

  modport slave (
    input  pll_lock,
    input  soft_rst_req,
    output sys_rst_n,
    output bus_rst_n,
    output ready,
    output lock_loss_cnt,
    output pll_reset
  );
endinterface

// File: rtl/pll_reset_seq.sv
// Reset sequencer after the 108 MHz PLL: synchronizes lock, releases core then bus reset, counts lock losses.
// Reacts SYNC_STAGES+1 edges after pll_lock changes; no backpressure. Optional PLL kick under PLL_WATCHDOG_EN.
module pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP_CYCLES   = 256,
  parameter int WDOG_CYCLES        = 1048576
) (
  input logic            clk,
  input logic            rst_n,
  pll_reset_seq_if.slave seq
);

  localparam int CMAX_A = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
  localparam int CMAX   = (CMAX_A > WDOG_CYCLES) ? CMAX_A : WDOG_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP_CYCLES - 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABLE    = 2'd1;
  localparam logic [1:0] REL_SYS   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic                   sys_q;
  logic                   bus_q;
  logic                   ready_q;
  logic [7:0]             loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], seq.pll_lock};
    end
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      sys_q   <= 1'b0;
      bus_q   <= 1'b0;
      ready_q <= 1'b0;
      loss_q  <= 8'd0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt     <= '0;
          sys_q   <= 1'b0;
          bus_q   <= 1'b0;
          ready_q <= 1'b0;
          if (lock_s) begin
            state <= STABLE;
          end
        end

        // A glitch before release is not a lock loss, just a restart of the hold.
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= REL_SYS;
            sys_q <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Lock loss outranks a simultaneous soft request.
        REL_SYS, RUN: begin
          if (!lock_s) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            sys_q   <= 1'b0;
            bus_q   <= 1'b0;
            ready_q <= 1'b0;
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 8'd1;
            end
          end else if (seq.soft_rst_req) begin
            state   <= STABLE;
            cnt     <= '0;
            sys_q   <= 1'b0;
            bus_q   <= 1'b0;
            ready_q <= 1'b0;
          end else if (state == REL_SYS) begin
            if (cnt == GAP_LAST) begin
              state   <= RUN;
              bus_q   <= 1'b1;
              ready_q <= 1'b1;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= WAIT_LOCK;
          cnt     <= '0;
          sys_q   <= 1'b0;
          bus_q   <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign seq.sys_rst_n     = sys_q;
  assign seq.bus_rst_n     = bus_q;
  assign seq.ready         = ready_q;
  assign seq.lock_loss_cnt = loss_q;

`ifdef PLL_WATCHDOG_EN
  logic [CW-1:0] wd_cnt;
  logic [3:0]    pulse_cnt;
  logic          pll_reset_q;

  // A started pulse always runs its full 16 cycles, even if lock arrives meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      pulse_cnt   <= 4'd0;
      pll_reset_q <= 1'b0;
    end else if (pll_reset_q) begin
      if (pulse_cnt == 4'd15) begin
        pll_reset_q <= 1'b0;
        pulse_cnt   <= 4'd0;
        wd_cnt      <= '0;
      end else begin
        pulse_cnt <= pulse_cnt + 4'd1;
      end
    end else if (state != WAIT_LOCK) begin
      wd_cnt <= '0;
    end else if (wd_cnt == CW'(WDOG_CYCLES - 1)) begin
      pll_reset_q <= 1'b1;
      pulse_cnt   <= 4'd0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign seq.pll_reset = pll_reset_q;
`else
  assign seq.pll_reset = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomized bench for pll_reset_seq against a timestamp-based reference model.
module tb_pll_reset_seq;
  localparam int LSC  = 16;
  localparam int GAP  = 8;
  localparam int WDOG = 64;
`ifdef PLL_WATCHDOG_EN
  localparam logic [11:0] MASK = 12'hEFF;
`else
  localparam logic [11:0] MASK = 12'hFFF;
`endif

  logic clk = 1'b0;
  logic rst_n;
  pll_reset_seq_if sif();

  pll_reset_seq #(
    .SYNC_STAGES(2),
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP_CYCLES(GAP),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seq(sif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: e = edges since reset release, hs = edge at which the current lock hold began (-1 = none).
  int   e;
  int   hs;
  int   m_loss;
  logic h0, h1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask

  function automatic logic [11:0] outs();
    return {sif.sys_rst_n, sif.bus_rst_n, sif.ready, sif.pll_reset, sif.lock_loss_cnt};
  endfunction

  function automatic logic [11:0] model_outs();
    logic s, b;
    s = (hs >= 0) && (e >= hs + LSC);
    b = (hs >= 0) && (e >= hs + LSC + GAP);
    return {s, b, b, 1'b0, m_loss[7:0]};
  endfunction

  task automatic tick();
    logic ls;
    logic released;
    @(posedge clk);
    e++;
    ls = h1;
    h1 = h0;
    h0 = sif.pll_lock;
    if (hs < 0) begin
      if (ls) hs = e;
    end else begin
      released = (e > hs + LSC);
      if (!ls) begin
        if (released && m_loss < 255) m_loss++;
        hs = -1;
      end else if (sif.soft_rst_req && released) begin
        hs = e;
      end
    end
    #1;
    check("cycle", outs() & MASK, model_outs() & MASK);
  endtask

  task automatic apply_reset(input logic lk);
    rst_n            = 1'b0;
    sif.pll_lock     = lk;
    sif.soft_rst_req = 1'b0;
    #2;
    check("rst_outs", outs(), 12'h000);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    e      = 0;
    hs     = -1;
    h0     = 1'b0;
    h1     = 1'b0;
    m_loss = 0;
  endtask

  task automatic rel_edges(output int s, output int b);
    s = -1;
    b = -1;
    for (int i = 0; i < 80 && b < 0; i++) begin
      tick();
      if (sif.sys_rst_n && s < 0) s = e;
      if (sif.bus_rst_n) b = e;
    end
    check("release_timeout", b >= 0, 1);
  endtask

  initial begin
    int s, b, t0, kind, len;
    logic exp_pr;
    rst_n            = 1'b1;
    sif.pll_lock     = 1'b1;
    sif.soft_rst_req = 1'b0;
    e = 0; hs = -1; m_loss = 0; h0 = 1'b0; h1 = 1'b0;
    #1;

    // Power-up release with lock held high
    apply_reset(1'b1);
    rel_edges(s, b);
    check("sys_rel_edge", s, 19);
    check("bus_rel_edge", b, 27);
    check("ready_with_bus", sif.ready, 1);

    // Lock glitch during the stability hold
    apply_reset(1'b1);
    while (e < 13) tick();
    sif.pll_lock = 1'b0;
    repeat (3) tick();
    sif.pll_lock = 1'b1;
    rel_edges(s, b);
    check("relock_sys_edge", s, 35);
    check("stable_drop_loss", sif.lock_loss_cnt, 0);

    // Lock loss in RUN
    sif.pll_lock = 1'b0;
    tick();
    tick();
    check("run_drop_ready_held", sif.ready, 1);
    tick();
    check("run_drop_outs", {sif.sys_rst_n, sif.bus_rst_n, sif.ready}, 0);
    check("run_drop_loss", sif.lock_loss_cnt, 1);
    sif.pll_lock = 1'b1;
    rel_edges(s, b);

    // Soft reset request in RUN
    sif.soft_rst_req = 1'b1;
    tick();
    sif.soft_rst_req = 1'b0;
    t0 = e;
    check("soft_sys_low", sif.sys_rst_n, 0);
    check("soft_bus_low", sif.bus_rst_n, 0);
    rel_edges(s, b);
    check("soft_sys_delay", s - t0, 16);
    check("soft_bus_delay", b - s, 8);
    check("soft_loss", sif.lock_loss_cnt, 1);

    // Random lock/soft-request traffic
    for (int seg = 0; seg < 150; seg++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        sif.pll_lock = 1'b1;
        len = $urandom_range(1, 40);
        for (int k = 0; k < len; k++) begin
          sif.soft_rst_req = ($urandom_range(0, 11) == 0);
          tick();
        end
      end else begin
        sif.pll_lock = 1'b0;
        len = (kind == 9) ? $urandom_range(5, 12) : $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          sif.soft_rst_req = ($urandom_range(0, 3) == 0);
          tick();
        end
      end
      sif.soft_rst_req = 1'b0;
    end

    // Loss counter saturation
    apply_reset(1'b1);
    for (int n = 0; n < 300; n++) begin
      rel_edges(s, b);
      sif.pll_lock = 1'b0;
      repeat (3) tick();
      sif.pll_lock = 1'b1;
    end
    check("loss_saturated", sif.lock_loss_cnt, 255);

    // Asynchronous reset while in REL_SYS
    for (int i = 0; i < 60 && !(sif.sys_rst_n && !sif.bus_rst_n); i++) tick();
    check("reached_rel_sys", {sif.sys_rst_n, sif.bus_rst_n}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", outs(), 12'h000);

    // Watchdog kick with lock never arriving
    apply_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      tick();
`ifdef PLL_WATCHDOG_EN
      exp_pr = (e >= WDOG) && (((e - WDOG) % (WDOG + 16)) < 16);
`else
      exp_pr = 1'b0;
`endif
      check("pll_reset", sif.pll_reset, exp_pr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
Reset sequencer directly downstream of the 108 MHz PLL. It consumes the PLL's asynchronous lock indication and the board-level reset. It produces synchronized, staged active-low resets for the core logic and then the cartridge bus logic. It also tracks lock losses and can optionally re-kick a PLL that never locks.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the pll_lock synchronizer (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before sys_rst_n releases (min 1)
STAGE_GAP_CYCLES, 256, cycles between sys_rst_n release and bus_rst_n release (min 1)
WDOG_CYCLES, 1048576, cycles in WAIT_LOCK before the PLL kick (used only with PLL_WATCHDOG_EN)

Ports:
clk  input  1  108 MHz clock from PLL clkout
rst_n  input  1  asynchronous active-low reset
pll_lock  input  1  PLL lock, asynchronous to clk
soft_rst_req  input  1  synchronous one-cycle request to re-run the reset sequence
sys_rst_n  output  1  core reset, active-low, registered
bus_rst_n  output  1  cartridge bus reset, active-low, registered
ready  output  1  high when both resets are released
lock_loss_cnt  output  8  saturating count of lock losses after release
pll_reset  output  1  active-high reset toward the PLL RESET pin

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- rst_n low immediately forces: state=WAIT_LOCK, sys_rst_n=0, bus_rst_n=0, ready=0, lock_loss_cnt=0, pll_reset=0, counters=0, synchronizer=0.
- All outputs are registered. Reset deassertion is always synchronous to clk.
- lock_s is pll_lock passed through SYNC_STAGES flops, which gives SYNC_STAGES cycles of latency.
- WAIT_LOCK:
  - Outputs: sys_rst_n=0, bus_rst_n=0, ready=0, cnt=0.
  - lock_s=1 -> STABLE.
- STABLE:
  - cnt increments each cycle while lock_s=1.
  - lock_s=0 -> WAIT_LOCK, cnt=0. lock_loss_cnt is not incremented.
  - cnt==LOCK_STABLE_CYCLES-1 with lock_s=1 -> REL_SYS, sys_rst_n=1, cnt=0.
  - Net timing: sys_rst_n rises LOCK_STABLE_CYCLES+1 edges after the first edge that samples lock_s=1 in WAIT_LOCK.
- REL_SYS:
  - cnt increments each cycle.
  - cnt==STAGE_GAP_CYCLES-1 -> RUN, bus_rst_n=1, ready=1.
  - Net timing: bus_rst_n rises exactly STAGE_GAP_CYCLES edges after sys_rst_n.
- RUN: holds until lock loss or soft_rst_req.
- Lock loss in REL_SYS or RUN (lock_s=0):
  - Next edge: state=WAIT_LOCK, sys_rst_n=0, bus_rst_n=0, ready=0, cnt=0.
  - lock_loss_cnt increments by 1 and saturates at 8'hFF.
- soft_rst_req=1 in REL_SYS or RUN with lock_s=1:
  - Next edge: state=STABLE, sys_rst_n=0, bus_rst_n=0, ready=0, cnt=0.
  - No count increment. The full hold time is re-run.
  - Ignored in WAIT_LOCK and STABLE.
- Simultaneous lock loss and soft_rst_req: lock loss wins, so the state goes to WAIT_LOCK and the count increments.
- Reset polarity: bus_rst_n is never 1 while sys_rst_n is 0. Both resets assert on the same edge.
- Counter width: counter wide enough for max(LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES, WDOG_CYCLES). No wrap is possible.

Optional Feature:
PLL_WATCHDOG_EN
- Defined:
  - A watchdog counter runs while state==WAIT_LOCK and clears on any other state.
  - On reaching WDOG_CYCLES-1 it drives pll_reset=1 for exactly 16 cycles, then 0, then clears and restarts.
  - The synchronizer keeps sampling during the pulse. lock_s rising during the pulse still moves the state to STABLE, and the pulse completes its 16 cycles.
- Undefined: pll_reset is constant 0 and no watchdog logic is built.

Test Plan:
All scenarios use LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=8, SYNC_STAGES=2, WDOG_CYCLES=64.
- rst_n low, pll_lock=1 -> all outputs 0. rst_n released, pll_lock held 1 -> sys_rst_n rises at edge 2+1+16=19 after release, bus_rst_n at edge 27, ready=1 with bus_rst_n.
- pll_lock drops for 3 cycles during STABLE (cnt=10) -> back to WAIT_LOCK, lock_loss_cnt=0. Full 16-cycle hold restarts after re-lock.
- pll_lock drops in RUN -> sys_rst_n, bus_rst_n and ready all 0 three edges later (2 sync + 1), lock_loss_cnt=1. Repeating 300 times -> lock_loss_cnt=255.
- soft_rst_req pulse in RUN -> resets asserted next edge. sys_rst_n re-released 16 edges later, bus_rst_n 8 after that, lock_loss_cnt unchanged.
- rst_n asserted mid-REL_SYS -> outputs 0 with no clock edge, lock_loss_cnt=0.
- PLL_WATCHDOG_EN defined, pll_lock=0 -> pll_reset high for 16 cycles every 80 cycles. Without the macro -> pll_reset stays 0.
